// File: rtl/pe_array_seq_ctrl_pkg.sv
// Shared types and constants for the PE array job sequencer.
package pe_array_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Precision field codes (one field each for activations and weights)
    localparam logic [1:0] PREC_1B  = 2'b00;
    localparam logic [1:0] PREC_2B  = 2'b01;
    localparam logic [1:0] PREC_4B  = 2'b10;
    localparam logic [1:0] PREC_INV = 2'b11;

    localparam int unsigned N_BIAS_DEF    = 16;
    localparam int unsigned BITS_PSUM_DEF = 32;

    // A precision code is usable when neither field carries the invalid code
    function automatic logic prec_ok(input logic [3:0] prec);
        return (prec[3:2] != PREC_INV) && (prec[1:0] != PREC_INV);
    endfunction

endpackage

// File: rtl/pe_array_seq_ctrl_delay_pipe.sv
// Fixed-depth shift pipe aligning beat markers with the operand read latency.
module pe_ctrl_delay_pipe #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift every stage by one position, new sample enters stage 0
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Job sequencer for the 64-lane precision-fused PE array.
module pe_array_seq_ctrl
    import pe_array_seq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned ARRAY_LAT = 3,
    parameter int unsigned N_BIAS    = N_BIAS_DEF,
    parameter int unsigned BITS_PSUM = BITS_PSUM_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [3:0]           job_prec,
    input  logic [LEN_W-1:0]     job_len,
    input  logic [ADDR_W-1:0]    job_base,
    input  logic [N_BIAS-1:0]    job_bias,
    output logic                 op_req,
    output logic [ADDR_W-1:0]    op_addr,
    input  logic                 op_gnt,
    output logic [3:0]           pe_precision,
    output logic [N_BIAS-1:0]    pe_bias,
    output logic                 pe_sel_bias,
    output logic                 pe_core_vld,
    output logic                 pe_flush,
    input  logic [BITS_PSUM-1:0] pe_psum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BITS_PSUM-1:0] res_data,
    output logic                 err_valid,
    output logic                 busy
);

    localparam int unsigned DRAIN_LOAD = RD_LAT + ARRAY_LAT;
    localparam int unsigned DRAIN_W    = $clog2(DRAIN_LOAD + 1);

    state_e                 state_q, state_d;
    logic [3:0]             prec_q, prec_d;
    logic [N_BIAS-1:0]      bias_q, bias_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [BITS_PSUM-1:0]   res_data_q, res_data_d;
    logic                   err_q, err_d;
    logic                   flush_q, flush_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic                   job_ok;
    logic                   grant;
    logic                   res_take;
    logic [1:0]             beat_in;
    logic [1:0]             beat_out;

    assign accept   = job_valid && ready_q;
    assign job_ok   = prec_ok(job_prec) && (job_len != '0);
    assign grant    = (state_q == ST_ISSUE) && op_gnt;
    assign res_take = res_valid_q && res_ready;

    // Next-state logic for the sequencer FSM, counters and result holding register
    always_comb begin
        state_d     = state_q;
        prec_d      = prec_q;
        bias_d      = bias_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        base_d      = base_q;
        drain_cnt_d = drain_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = 1'b0;
        flush_d     = 1'b0;

        if (res_take) res_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (job_ok) begin
                        prec_d     = job_prec;
                        bias_d     = job_bias;
                        len_d      = job_len;
                        base_d     = job_base;
                        beat_cnt_d = '0;
                        state_d    = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_gnt) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == len_q - 1'b1) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_W'(DRAIN_LOAD);
                    end
                end
            end
            ST_DRAIN: begin
                // The edge that brings the counter to 0 is also the capture edge,
                // so the last beat's contribution is just visible on pe_psum.
                if (drain_cnt_q > DRAIN_W'(1)) begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end else begin
                    drain_cnt_d = '0;
                    if (!res_valid_q || res_ready) begin
                        res_valid_d = 1'b1;
                        res_data_d  = pe_psum;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            prec_q      <= '0;
            bias_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            base_q      <= '0;
            drain_cnt_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            flush_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            bias_q      <= bias_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            base_q      <= base_d;
            drain_cnt_q <= drain_cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            flush_q     <= flush_d;
            ready_q     <= ready_d;
        end
    end

    assign beat_in = {grant, grant && (beat_cnt_q == '0)};

    pe_ctrl_delay_pipe #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_beat_pipe (
        .clk   (CLK),
        .rst_n (RST),
        .din   (beat_in),
        .dout  (beat_out)
    );

    assign job_ready    = ready_q;
    assign op_req       = (state_q == ST_ISSUE);
    assign op_addr      = base_q + ADDR_W'(beat_cnt_q);
    assign pe_precision = prec_q;
    assign pe_bias      = bias_q;
    assign pe_core_vld  = beat_out[1];
    assign pe_sel_bias  = beat_out[0];
    assign pe_flush     = flush_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign err_valid    = err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Directed bench for the PE array job sequencer.
module tb_pe_array_seq_ctrl;

    localparam logic [31:0] PSUM_BASE = 32'h1000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [3:0]  job_prec = '0;
    logic [7:0]  job_len = '0;
    logic [9:0]  job_base = '0;
    logic [15:0] job_bias = '0;
    logic        op_req;
    logic [9:0]  op_addr;
    logic        op_gnt = 1'b0;
    logic [3:0]  pe_precision;
    logic [15:0] pe_bias;
    logic        pe_sel_bias;
    logic        pe_core_vld;
    logic        pe_flush;
    logic [31:0] pe_psum = PSUM_BASE;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        err_valid;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned t0;
    int unsigned seen;

    logic [9:0] t1_addr [4];
    logic [9:0] t2_addr [5];
    logic [0:4] t2_gnt;

    pe_array_seq_ctrl #(
        .ADDR_W    (10),
        .LEN_W     (8),
        .RD_LAT    (1),
        .ARRAY_LAT (3),
        .N_BIAS    (16),
        .BITS_PSUM (32)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_prec     (job_prec),
        .job_len      (job_len),
        .job_base     (job_base),
        .job_bias     (job_bias),
        .op_req       (op_req),
        .op_addr      (op_addr),
        .op_gnt       (op_gnt),
        .pe_precision (pe_precision),
        .pe_bias      (pe_bias),
        .pe_sel_bias  (pe_sel_bias),
        .pe_core_vld  (pe_core_vld),
        .pe_flush     (pe_flush),
        .pe_psum      (pe_psum),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .err_valid    (err_valid),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; psum tracks the cycle number so captures are traceable
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        pe_psum = PSUM_BASE + cyc;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_job_ready"}, job_ready, 0);
        chk({pfx, "_op_req"}, op_req, 0);
        chk({pfx, "_op_addr"}, op_addr, 0);
        chk({pfx, "_prec"}, pe_precision, 0);
        chk({pfx, "_bias"}, pe_bias, 0);
        chk({pfx, "_sel_bias"}, pe_sel_bias, 0);
        chk({pfx, "_core_vld"}, pe_core_vld, 0);
        chk({pfx, "_flush"}, pe_flush, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_data"}, res_data, 0);
        chk({pfx, "_err"}, err_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    initial begin
        t1_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        t2_addr = '{10'h100, 10'h101, 10'h101, 10'h101, 10'h102};
        t2_gnt  = 5'b10011;

        // Reset state
        #2;
        chk_all_zero("rst");
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("rst_ready_after", job_ready, 1);

        // Test 1: 4-beat job wrapping the address space, continuous grants
        job_prec = 4'b1010; job_len = 8'd4; job_base = 10'h3FE; job_bias = 16'hFFFB;
        job_valid = 1'b1; res_ready = 1'b1; op_gnt = 1'b1;
        chk("t1_ready", job_ready, 1);
        t0 = cyc;
        tick();
        job_valid = 1'b0;
        chk("t1_prec", pe_precision, 4'b1010);
        chk("t1_bias", pe_bias, 16'hFFFB);
        chk("t1_busy", busy, 1);
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) tick();
            chk($sformatf("t1_req[%0d]", k), op_req, (k <= 4));
            if (k <= 4) chk($sformatf("t1_addr[%0d]", k), op_addr, t1_addr[k-1]);
            chk($sformatf("t1_vld[%0d]", k), pe_core_vld, (k >= 2 && k <= 5));
            chk($sformatf("t1_sel[%0d]", k), pe_sel_bias, (k == 2));
            chk($sformatf("t1_rv[%0d]", k), res_valid, (k == 9));
            chk($sformatf("t1_flush[%0d]", k), pe_flush, (k == 10));
            if (k == 9) chk("t1_data", res_data, PSUM_BASE + t0 + 8);
        end

        // Test 2: grant gaps become core_vld bubbles
        job_prec = 4'b0101; job_len = 8'd3; job_base = 10'h100; job_bias = 16'h0002;
        job_valid = 1'b1; op_gnt = 1'b0;
        t0 = cyc;
        tick();
        job_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            op_gnt = (k <= 5) ? t2_gnt[k-1] : 1'b0;
            chk($sformatf("t2_req[%0d]", k), op_req, (k <= 5));
            if (k <= 5) chk($sformatf("t2_addr[%0d]", k), op_addr, t2_addr[k-1]);
            chk($sformatf("t2_vld[%0d]", k), pe_core_vld, (k >= 2 && k <= 6) ? t2_gnt[k-2] : 1'b0);
            chk($sformatf("t2_sel[%0d]", k), pe_sel_bias, (k == 2));
            chk($sformatf("t2_rv[%0d]", k), res_valid, (k == 10));
            chk($sformatf("t2_flush[%0d]", k), pe_flush, (k == 11));
            if (k == 10) chk("t2_data", res_data, PSUM_BASE + t0 + 9);
        end
        op_gnt = 1'b1;

        // Test 3: consumer stalled across two jobs
        res_ready = 1'b0;
        job_prec = 4'b0101; job_len = 8'd2; job_base = 10'h000; job_bias = 16'h0001;
        job_valid = 1'b1;
        t0 = cyc;
        tick();
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) tick();
            job_valid = 1'b0;
            chk($sformatf("t3_rv[%0d]", k), res_valid, (k >= 7 && k <= 17));
            chk($sformatf("t3_flush[%0d]", k), pe_flush, (k == 8 || k == 18));
            chk($sformatf("t3_busy[%0d]", k), busy, ((k >= 1 && k <= 7) || (k >= 9 && k <= 17)));
            if (k >= 7 && k <= 16) chk($sformatf("t3_dataA[%0d]", k), res_data, PSUM_BASE + t0 + 6);
            if (k == 17) chk("t3_dataB", res_data, PSUM_BASE + t0 + 16);
            if (k == 8) begin
                chk("t3_ready8", job_ready, 1);
                chk("t3_prec8", pe_precision, 4'b0101);
                job_prec = 4'b0000; job_len = 8'd1; job_base = 10'h010; job_bias = 16'h0007;
                job_valid = 1'b1;
            end
            if (k == 9) chk("t3_prec9", pe_precision, 4'b0000);
            if (k == 16) res_ready = 1'b1;
        end

        // Test 4: invalid jobs are accepted, flagged and otherwise ignored
        job_prec = 4'b1100; job_len = 8'd5; job_valid = 1'b1;
        chk("t4a_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
        chk("t4a_err", err_valid, 1);
        chk("t4a_busy", busy, 0);
        chk("t4a_ready1", job_ready, 1);
        chk("t4a_prec", pe_precision, 4'b0000);
        chk("t4a_bias", pe_bias, 16'h0007);
        tick();
        chk("t4a_err_end", err_valid, 0);
        chk("t4a_req", op_req, 0);
        job_prec = 4'b0101; job_len = 8'd0; job_bias = 16'h0063; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("t4b_err", err_valid, 1);
        chk("t4b_busy", busy, 0);
        chk("t4b_prec", pe_precision, 4'b0000);
        chk("t4b_bias", pe_bias, 16'h0007);
        tick();
        chk("t4b_err_end", err_valid, 0);
        chk("t4b_busy_end", busy, 0);

        // Test 5: reset in the middle of a job
        job_prec = 4'b1010; job_len = 8'd6; job_base = 10'h050; job_bias = 16'h0003;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("t5_addr0", op_addr, 10'h050);
        tick();
        chk("t5_addr1", op_addr, 10'h051);
        tick();
        chk("t5_addr2", op_addr, 10'h052);
        #2;
        RST = 1'b0;
        #1;
        chk_all_zero("t5");
        tick();
        RST = 1'b1;
        tick();
        chk("t5_ready", job_ready, 1);
        chk("t5_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (res_valid || pe_flush || err_valid || op_req) seen++;
        end
        chk("t5_no_result", seen, 0);

        // Test 6: back-to-back valid jobs, second waits for the flush
        res_ready = 1'b1;
        job_prec = 4'b1001; job_len = 8'd1; job_base = 10'h200; job_bias = 16'h0003;
        job_valid = 1'b1;
        t0 = cyc;
        tick();
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) tick();
            if (k == 1) begin
                job_prec = 4'b0110; job_len = 8'd1; job_base = 10'h300; job_bias = 16'h0009;
            end
            if (k == 8) job_valid = 1'b0;
            chk($sformatf("t6_ready[%0d]", k), job_ready, (k == 7 || k == 14));
            chk($sformatf("t6_prec[%0d]", k), pe_precision, (k <= 7) ? 4'b1001 : 4'b0110);
            chk($sformatf("t6_rv[%0d]", k), res_valid, (k == 6 || k == 13));
            chk($sformatf("t6_flush[%0d]", k), pe_flush, (k == 7 || k == 14));
            if (k == 6) chk("t6_dataC", res_data, PSUM_BASE + t0 + 5);
            if (k == 13) chk("t6_dataD", res_data, PSUM_BASE + t0 + 12);
        end
        chk("t6_bias", pe_bias, 16'h0009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
